// File: rtl/isp_pass_sequencer.sv
// isp_pass_sequencer: frame-level controller for the ISP stage pipeline.
// Runs one pass (SINGLE, GAMMA_ONLY) or a statistics pass, a white-balance
// gain calculation and an apply pass (AWB, FULL). Gains come from a
// restoring divider that produces one quotient bit per cycle.
// Latency: start at edge t gives frame_req in cycle t+1. In AWB/FULL the
// second frame_req comes 2*GAIN_W+1 cycles after the last statistics beat.
// Backpressure: none. Samples are consumed on every s_valid beat.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start, mode_in      begin request (accepted only in IDLE) and pass mode
//   s_valid/s_pixel/s_color/s_last_pic
//                       post-denoise sample stream
//   frame_req           one-cycle replay request to upstream
//   pass_stats          high during the statistics pass
//   wb_en, gam_en       stage enables for the current pass
//   gain_r/g/b          white-balance gains (unsigned, FRAC fractional bits)
//   gain_valid          gains are final for this operation
//   busy                high outside IDLE
//   finish_operation    one-cycle completion pulse
//   err                 sticky flag: VOID sample seen inside a pass
module isp_pass_sequencer #(
    parameter int COLOR_DEPTH = 8,
    parameter int SUM_W       = 32,
    parameter int GAIN_W      = 12,
    parameter int FRAC        = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [1:0]             mode_in,
    input  logic                   s_valid,
    input  logic [COLOR_DEPTH-1:0] s_pixel,
    input  logic [1:0]             s_color,
    input  logic                   s_last_pic,
    output logic                   frame_req,
    output logic                   pass_stats,
    output logic                   wb_en,
    output logic                   gam_en,
    output logic [GAIN_W-1:0]      gain_r,
    output logic [GAIN_W-1:0]      gain_g,
    output logic [GAIN_W-1:0]      gain_b,
    output logic                   gain_valid,
    output logic                   busy,
    output logic                   finish_operation,
    output logic                   err
);

    localparam int NW = SUM_W + FRAC;
    localparam int CW = (GAIN_W > 1) ? $clog2(GAIN_W) : 1;
    localparam logic [GAIN_W-1:0] GAIN_ONE = GAIN_W'(1 << FRAC);
    localparam logic [GAIN_W-1:0] GAIN_MAX = '1;
    localparam logic [CW-1:0]     CNT_END  = CW'(GAIN_W - 1);

    localparam logic [1:0] COL_VOID  = 2'd0;
    localparam logic [1:0] COL_RED   = 2'd1;
    localparam logic [1:0] COL_GREEN = 2'd2;
    localparam logic [1:0] COL_BLUE  = 2'd3;

    typedef enum logic [3:0] {
        IDLE,
        LAUNCH1,
        PASS,
        STATS,
        DIV_R,
        DIV_B,
        LAUNCH2,
        APPLY,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [1:0]        mode;
    logic [SUM_W-1:0]  sum_r, sum_g, sum_b;
    logic [GAIN_W-1:0] gain_r_q, gain_b_q;
    logic              gain_valid_q;
    logic              err_q;

    // Divider working registers
    logic [CW-1:0]     cnt;
    logic [SUM_W-1:0]  rem;
    logic [GAIN_W-1:0] nlo;
    logic [GAIN_W-1:0] quo;
    logic              sat_q;

    logic last_beat;
    logic cnt_last;
    assign last_beat = s_valid & s_last_pic;
    assign cnt_last  = (cnt == CNT_END);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LAUNCH1;
            LAUNCH1: state_nxt = mode[1] ? STATS : PASS;
            PASS:    if (last_beat) state_nxt = DONE;
            STATS:   if (last_beat) state_nxt = DIV_R;
            DIV_R:   if (cnt_last) state_nxt = DIV_B;
            DIV_B:   if (cnt_last) state_nxt = LAUNCH2;
            LAUNCH2: state_nxt = APPLY;
            APPLY:   if (last_beat) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Restoring divider: floor((sum_g << FRAC) / sum_c), MSB first.
    // On the first cycle of a DIV state the working values are taken
    // straight from the sums, so the full GAIN_W cycles all yield a bit.
    // The initial partial remainder is the numerator shifted down by
    // GAIN_W; the remaining GAIN_W low bits are shifted in one per cycle.
    // ------------------------------------------------------------------
    logic [NW-1:0]     numer;
    logic [NW-1:0]     numer_hi;
    logic [SUM_W-1:0]  divisor;
    logic              first;
    logic [SUM_W-1:0]  cur_rem;
    logic [GAIN_W-1:0] cur_lo;
    logic [GAIN_W-1:0] cur_q;
    logic              cur_sat;
    logic [SUM_W:0]    trial;
    logic [SUM_W-1:0]  sub;
    logic              take;
    logic [SUM_W-1:0]  rem_nxt;
    logic [GAIN_W-1:0] q_nxt;
    logic [GAIN_W-1:0] lo_nxt;
    logic [GAIN_W-1:0] gain_res;

    always_comb begin
        numer    = NW'(sum_g) << FRAC;
        numer_hi = numer >> GAIN_W;
        divisor  = (state == DIV_B) ? sum_b : sum_r;
        first    = (cnt == '0);
        cur_rem  = first ? numer_hi[SUM_W-1:0] : rem;
        cur_lo   = first ? numer[GAIN_W-1:0]   : nlo;
        cur_q    = first ? '0                  : quo;
        // A quotient that would not fit in GAIN_W bits (or a zero divisor)
        // clamps to full scale; decided once, on the first divide cycle.
        cur_sat  = first ? ((divisor == '0) || (numer_hi >= NW'(divisor))) : sat_q;
        trial    = {cur_rem, cur_lo[GAIN_W-1]};
        take     = (trial >= {1'b0, divisor});
        // When take is set the true difference is below divisor, so the
        // low SUM_W bits of the subtraction are exact.
        sub      = trial[SUM_W-1:0] - divisor;
        rem_nxt  = take ? sub : trial[SUM_W-1:0];
        q_nxt    = {cur_q[GAIN_W-2:0], take};
        lo_nxt   = {cur_lo[GAIN_W-2:0], 1'b0};
        gain_res = cur_sat ? GAIN_MAX : q_nxt;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mode         <= '0;
            sum_r        <= '0;
            sum_g        <= '0;
            sum_b        <= '0;
            gain_r_q     <= GAIN_ONE;
            gain_b_q     <= GAIN_ONE;
            gain_valid_q <= 1'b0;
            err_q        <= 1'b0;
            cnt          <= '0;
            rem          <= '0;
            nlo          <= '0;
            quo          <= '0;
            sat_q        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode         <= mode_in;
                        sum_r        <= '0;
                        sum_g        <= '0;
                        sum_b        <= '0;
                        gain_r_q     <= GAIN_ONE;
                        gain_b_q     <= GAIN_ONE;
                        gain_valid_q <= 1'b0;
                        err_q        <= 1'b0;
                        cnt          <= '0;
                    end
                end
                PASS, APPLY: begin
                    if (s_valid && (s_color == COL_VOID)) begin
                        err_q <= 1'b1;
                    end
                end
                STATS: begin
                    if (s_valid) begin
                        case (s_color)
                            COL_RED:   sum_r <= sum_r + SUM_W'(s_pixel);
                            COL_GREEN: sum_g <= sum_g + SUM_W'(s_pixel);
                            COL_BLUE:  sum_b <= sum_b + SUM_W'(s_pixel);
                            default:   err_q <= 1'b1;
                        endcase
                    end
                end
                DIV_R, DIV_B: begin
                    rem   <= rem_nxt;
                    nlo   <= lo_nxt;
                    quo   <= q_nxt;
                    sat_q <= cur_sat;
                    if (cnt_last) begin
                        cnt <= '0;
                        if (state == DIV_R) begin
                            gain_r_q <= gain_res;
                        end else begin
                            gain_b_q     <= gain_res;
                            // Visible from LAUNCH2 onward.
                            gain_valid_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Moore outputs
    // ------------------------------------------------------------------
    assign frame_req        = (state == LAUNCH1) || (state == LAUNCH2);
    assign pass_stats       = (state == STATS);
    assign wb_en            = (state == APPLY);
    assign gam_en           = ((state == PASS) && (mode == 2'd1)) ||
                              ((state == APPLY) && (mode == 2'd3));
    assign busy             = (state != IDLE);
    assign finish_operation = (state == DONE);
    assign gain_r           = gain_r_q;
    assign gain_g           = GAIN_ONE;
    assign gain_b           = gain_b_q;
    assign gain_valid       = gain_valid_q;
    assign err              = err_q;

endmodule

// File: tb/tb_isp_pass_sequencer.sv
module tb_isp_pass_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mode_in;
    logic        s_valid;
    logic [7:0]  s_pixel;
    logic [1:0]  s_color;
    logic        s_last_pic;
    logic        frame_req, pass_stats, wb_en, gam_en;
    logic [11:0] gain_r, gain_g, gain_b;
    logic        gain_valid, busy, finish_operation, err;

    always #5 clk = ~clk;

    isp_pass_sequencer #(
        .COLOR_DEPTH(8), .SUM_W(32), .GAIN_W(12), .FRAC(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode_in(mode_in),
        .s_valid(s_valid), .s_pixel(s_pixel), .s_color(s_color),
        .s_last_pic(s_last_pic), .frame_req(frame_req),
        .pass_stats(pass_stats), .wb_en(wb_en), .gam_en(gam_en),
        .gain_r(gain_r), .gain_g(gain_g), .gain_b(gain_b),
        .gain_valid(gain_valid), .busy(busy),
        .finish_operation(finish_operation), .err(err)
    );

    int checks = 0;
    int errors = 0;

    // Free-running event counters; the stimulus takes snapshots and diffs.
    int frq_cnt = 0, fin_cnt = 0, wb_cnt = 0, gam_cnt = 0;
    always @(posedge clk) begin
        frq_cnt <= frq_cnt + (frame_req ? 1 : 0);
        fin_cnt <= fin_cnt + (finish_operation ? 1 : 0);
        wb_cnt  <= wb_cnt + (wb_en ? 1 : 0);
        gam_cnt <= gam_cnt + (gam_en ? 1 : 0);
    end

    typedef struct {
        logic [11:0] gr;
        logic [11:0] gb;
        logic        er;
        logic        gv;
        int          frq;
        logic        gam_any;
        logic        wb_any;
    } exp_t;
    exp_t sb[$];

    typedef struct packed {
        logic [7:0] p;
        logic [1:0] c;
    } beat_t;
    beat_t fr[$];

    int base_frq, base_fin, base_wb, base_gam;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic push_exp(input logic [11:0] gr, input logic [11:0] gb, input logic er,
                            input logic gv, input int frq, input logic ga, input logic wa);
        exp_t e;
        e.gr = gr; e.gb = gb; e.er = er; e.gv = gv;
        e.frq = frq; e.gam_any = ga; e.wb_any = wa;
        sb.push_back(e);
    endtask

    task automatic add(input logic [7:0] p, input logic [1:0] c);
        beat_t b;
        b.p = p; b.c = c;
        fr.push_back(b);
    endtask

    // Returns at the sampling point of the cycle after the last beat.
    task automatic send_frame();
        for (int i = 0; i < fr.size(); i++) begin
            @(negedge clk);
            s_valid    = 1'b1;
            s_pixel    = fr[i].p;
            s_color    = fr[i].c;
            s_last_pic = (i == fr.size() - 1);
        end
        @(negedge clk);
        s_valid    = 1'b0;
        s_last_pic = 1'b0;
        s_pixel    = '0;
        s_color    = '0;
        fr.delete();
    endtask

    // Returns in the LAUNCH1 cycle.
    task automatic do_start(input logic [1:0] m);
        @(negedge clk);
        base_frq = frq_cnt; base_fin = fin_cnt; base_wb = wb_cnt; base_gam = gam_cnt;
        start   = 1'b1;
        mode_in = m;
        @(negedge clk);
        start   = 1'b0;
        mode_in = 2'd0;
        chk("launch1_frame_req", frame_req, 1);
        chk("launch1_busy", busy, 1);
    endtask

    // Called in cycle e+1 after the last stats beat; returns in LAUNCH2 (e+25).
    task automatic awb_wait(input bit poke, input logic [11:0] gr, input logic [11:0] gb);
        chk("div_pass_stats", pass_stats, 0);
        if (poke) begin
            repeat (13) @(negedge clk);
            start   = 1'b1;
            mode_in = 2'd3;
            @(negedge clk);
            start   = 1'b0;
            mode_in = 2'd0;
            repeat (9) @(negedge clk);
        end else begin
            repeat (23) @(negedge clk);
        end
        chk("e24_frame_req", frame_req, 0);
        chk("e24_gain_valid", gain_valid, 0);
        @(negedge clk);
        chk("launch2_frame_req", frame_req, 1);
        chk("launch2_gain_valid", gain_valid, 1);
        chk("launch2_gain_r", gain_r, gr);
        chk("launch2_gain_b", gain_b, gb);
        chk("launch2_gain_g", gain_g, 256);
    endtask

    // Waits for DONE, compares against the scoreboard, and pokes a start
    // in the DONE cycle which must be ignored.
    task automatic finish_check();
        exp_t e;
        int k = 0;
        while (!finish_operation && k < 80) begin
            @(negedge clk);
            k++;
        end
        chk("finish_seen", finish_operation, 1);
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 0, 1);
        end else begin
            e = sb.pop_front();
            chk("done_gain_r", gain_r, e.gr);
            chk("done_gain_b", gain_b, e.gb);
            chk("done_gain_g", gain_g, 256);
            chk("done_gain_valid", gain_valid, e.gv);
            chk("done_err", err, e.er);
            start   = 1'b1;
            mode_in = 2'd3;
            @(negedge clk);
            start   = 1'b0;
            mode_in = 2'd0;
            chk("after_done_busy", busy, 0);
            chk("after_done_finish", finish_operation, 0);
            chk("after_done_frame_req", frame_req, 0);
            chk("hold_gain_valid", gain_valid, e.gv);
            @(negedge clk);
            chk("frame_req_count", frq_cnt - base_frq, e.frq);
            chk("finish_count", fin_cnt - base_fin, 1);
            chk("gam_seen", (gam_cnt != base_gam), e.gam_any);
            chk("wb_seen", (wb_cnt != base_wb), e.wb_any);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; mode_in = 2'd0;
        s_valid = 1'b0; s_pixel = '0; s_color = '0; s_last_pic = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_frame_req", frame_req, 0);
        chk("rst_pass_stats", pass_stats, 0);
        chk("rst_wb_en", wb_en, 0);
        chk("rst_gam_en", gam_en, 0);
        chk("rst_gain_r", gain_r, 256);
        chk("rst_gain_g", gain_g, 256);
        chk("rst_gain_b", gain_b, 256);
        chk("rst_gain_valid", gain_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_finish", finish_operation, 0);
        chk("rst_err", err, 0);

        // SINGLE: 4 RGB triplets, one replay, no enables.
        push_exp(12'd256, 12'd256, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        do_start(2'd0);
        for (int i = 0; i < 4; i++) begin
            add(8'(10 + i), 2'd1); add(8'(20 + i), 2'd2); add(8'(30 + i), 2'd3);
        end
        send_frame();
        chk("single_finish_timing", finish_operation, 1);
        chk("single_busy_in_done", busy, 1);
        finish_check();

        // FULL: sums R=100 G=200 B=400 -> gains 512 / 128.
        push_exp(12'd512, 12'd128, 1'b0, 1'b1, 2, 1'b1, 1'b1);
        do_start(2'd3);
        @(negedge clk);
        chk("stats_pass_stats", pass_stats, 1);
        add(8'd50, 2'd1); add(8'd100, 2'd2); add(8'd200, 2'd3);
        add(8'd50, 2'd1); add(8'd100, 2'd2); add(8'd200, 2'd3);
        send_frame();
        awb_wait(1'b0, 12'd512, 12'd128);
        @(negedge clk);
        chk("apply_wb_en", wb_en, 1);
        chk("apply_gam_en", gam_en, 1);
        add(8'd1, 2'd1); add(8'd2, 2'd2); add(8'd3, 2'd3);
        send_frame();
        chk("full_finish_timing", finish_operation, 1);
        finish_check();

        // AWB saturation: sum_r=10 sum_g=200 sum_b=0.
        push_exp(12'd4095, 12'd4095, 1'b0, 1'b1, 2, 1'b0, 1'b1);
        do_start(2'd2);
        add(8'd10, 2'd1); add(8'd100, 2'd2); add(8'd100, 2'd2);
        send_frame();
        awb_wait(1'b0, 12'd4095, 12'd4095);
        add(8'd5, 2'd1); add(8'd5, 2'd3);
        send_frame();
        finish_check();

        // AWB with a VOID beat mid-stats and a start during DIV_B.
        // Sums R=20 G=100 B=40 -> gains 1280 / 640.
        push_exp(12'd1280, 12'd640, 1'b1, 1'b1, 2, 1'b0, 1'b1);
        do_start(2'd2);
        add(8'd20, 2'd1); add(8'd99, 2'd0); add(8'd100, 2'd2); add(8'd40, 2'd3);
        send_frame();
        chk("void_err", err, 1);
        awb_wait(1'b1, 12'd1280, 12'd640);
        add(8'd7, 2'd2);
        send_frame();
        finish_check();

        // FULL aborted by rst during APPLY.
        do_start(2'd3);
        add(8'd100, 2'd1); add(8'd200, 2'd2); add(8'd200, 2'd3); add(8'd200, 2'd3);
        send_frame();
        awb_wait(1'b0, 12'd512, 12'd128);
        @(negedge clk);
        chk("abort_in_apply", wb_en, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_gain_valid", gain_valid, 0);
        chk("abort_gain_r", gain_r, 256);
        chk("abort_gain_b", gain_b, 256);
        chk("abort_finish", finish_operation, 0);
        repeat (2) @(negedge clk);
        chk("abort_no_finish_pulse", fin_cnt - base_fin, 0);

        // Fresh GAMMA_ONLY run after the abort.
        push_exp(12'd256, 12'd256, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        do_start(2'd1);
        @(negedge clk);
        chk("gamma_only_gam_en", gam_en, 1);
        add(8'd9, 2'd1); add(8'd9, 2'd2); add(8'd9, 2'd3);
        send_frame();
        finish_check();

        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/isp_pass_sequencer.md
Name: isp_pass_sequencer

Overview:
- Frame-level controller for the ISP pipeline, sitting between the top-level control (start, mode_in) and the stage datapath (demosaic, denoise, white balance, gamma).
- Sequences one or two frame passes depending on mode.
- In a statistics pass it accumulates per-channel sums from the post-denoise stream, then computes white-balance gains with a sequential divider.
- It then launches the apply pass with stage enables and gains driven to the datapath, and signals finish_operation when done.

Parameters:
COLOR_DEPTH, 8, pixel sample width
SUM_W, 32, per-channel accumulator width (wraps modulo 2^SUM_W; sized so no wrap occurs at 1024x1024)
GAIN_W, 12, gain width, unsigned fixed point
FRAC, 8, fractional bits of gain (1.0 = 1<<FRAC = 256)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle request to begin operation; ignored unless IDLE
mode_in  in  2  0=SINGLE, 1=GAMMA_ONLY, 2=AWB, 3=FULL; latched on accepted start
s_valid  in  1  post-denoise sample valid
s_pixel  in  COLOR_DEPTH  post-denoise sample
s_color  in  2  0=VOID, 1=RED, 2=GREEN, 3=BLUE
s_last_pic  in  1  marks final sample of the frame
frame_req  out  1  one-cycle pulse: upstream replays the frame from the start
pass_stats  out  1  high while in a statistics pass
wb_en  out  1  white-balance stage enable for the current pass
gam_en  out  1  gamma stage enable for the current pass
gain_r  out  GAIN_W  red gain
gain_g  out  GAIN_W  green gain, always 1<<FRAC
gain_b  out  GAIN_W  blue gain
gain_valid  out  1  gains are final
busy  out  1  high in every state except IDLE
finish_operation  out  1  one-cycle completion pulse
err  out  1  sticky: VOID sample received during a pass

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- rst has priority over all other inputs and may be asserted mid-operation. It forces:
  - state to IDLE;
  - accumulators and all outputs to 0;
  - gain_r, gain_g and gain_b to 256;
  - the latched mode to 0.
- States and transitions:
  - IDLE: on start, go to LAUNCH1, latch mode, clear sums, err and gain_valid. gain_r and gain_b are also reset to 256 on this transition.
  - LAUNCH1: frame_req=1 for this one cycle. Next state is STATS if mode>=2, otherwise PASS.
  - PASS: wait for an accepted sample with s_last_pic=1, then go to DONE.
  - STATS: pass_stats=1. On each s_valid, add s_pixel (zero-extended) to sum_r, sum_g or sum_b according to s_color. On the beat with s_last_pic, go to DIV_R.
  - DIV_R: exactly GAIN_W cycles, then go to DIV_B.
  - DIV_B: exactly GAIN_W cycles, then go to LAUNCH2.
  - LAUNCH2: frame_req=1 and gain_valid set to 1. Next state is APPLY.
  - APPLY: on the s_last_pic beat, go to DONE.
  - DONE: finish_operation=1 for one cycle, then go to IDLE. gain_valid holds until the next accepted start or rst.
- Outputs are Moore-decoded from registered state. Timing example: start sampled at edge t gives frame_req high in cycle t+1.
- Stage enables:
  - wb_en=1 only in APPLY.
  - gam_en=1 in PASS when mode=1, and in APPLY when mode=3.
  - All enables are 0 in every other state.
- s_valid with s_color=VOID during PASS, STATS or APPLY: set err, do not accumulate. s_last_pic on that beat still ends the pass.
- s_valid outside PASS, STATS or APPLY is ignored and does not set err.
- Gain arithmetic, computed for c in {r, b}:
  - Numerator N = sum_g<<FRAC. Quotient is floor(N/sum_c), computed by a restoring divider at one quotient bit per cycle, MSB first, over GAIN_W cycles.
  - Saturation: if sum_c==0 or (N>>GAIN_W)>=sum_c, the result is 2^GAIN_W-1. This is checked on the first cycle of DIV_x; the counter still runs the full GAIN_W cycles.
  - gain_r is written at the end of DIV_R and gain_b at the end of DIV_B.
- Latency in AWB/FULL modes: if the last stats beat is accepted at edge e, DIV_R occupies e+1..e+GAIN_W, DIV_B occupies the next GAIN_W cycles, and LAUNCH2 is cycle e+2*GAIN_W+1.
- A start arriving simultaneously with finish_operation (DONE) is ignored.
- s_last_pic during LAUNCH1 or LAUNCH2 is ignored.

Test Plan:
- rst held 3 cycles, then released with no start -> all outputs 0 except gain_r=gain_g=gain_b=256; busy=0.
- mode=0, start, 4 RGB triplets ending with s_last_pic -> exactly one frame_req pulse; wb_en=gam_en=0 throughout; finish_operation pulses one cycle after the last beat; busy falls with it.
- mode=3, stats pass with sums R=100, G=200, B=400 -> gain_r=512, gain_b=128, gain_g=256. Second frame_req pulse and gain_valid rise in cycle e+25; wb_en=gam_en=1 during the apply pass; finish_operation pulses after the apply pass's last beat.
- mode=2, stats with sum_r=10, sum_g=200 -> gain_r=4095 (saturated). Stats with sum_b=0 -> gain_b=4095. gam_en stays 0 throughout.
- mode=2, a VOID sample injected mid-stats -> err=1 and sums unchanged by that beat. A start pulsed during DIV_B is ignored (mode unchanged, no extra frame_req).
- rst asserted during APPLY -> next cycle state is IDLE, gain_valid=0, gains=256, no finish_operation pulse. A fresh start then runs normally.
